la32r_inst_encoder: RTL and testbench

Streaming LA32R instruction encoder: the inverse of the ID-stage control decoder. It accepts symbolic instruction requests (operation, register indices, immediate) over a valid/ready handshake. For each request it range-checks the immediate and packs a 32-bit LA32R instruction word, then emits the word with its target instruction-memory address over a registered valid/ready output. The block sits between the debug/boot loader and the instruction RAM write port, and is used to inject test programs and patch code at run time.

---
 rtl/la32r_inst_encoder_pkg.sv | 79 +++++++
 rtl/la32r_inst_encoder_pack.sv | 55 +++++
 rtl/la32r_inst_encoder.sv | 116 +++++++++++
 tb/tb_la32r_inst_encoder.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/la32r_inst_encoder_pkg.sv
// Shared types for the LA32R instruction encoder: op codes, format classes,
// rejection codes and the per-op base word / format lookup.
package enc_pkg;

    typedef enum logic [5:0] {
        OP_ADD_W, OP_SUB_W, OP_SLT, OP_SLTU, OP_NOR, OP_AND, OP_OR, OP_XOR,
        OP_SLL_W, OP_SRL_W, OP_SRA_W, OP_SLLI_W, OP_SRLI_W, OP_SRAI_W,
        OP_SLTI, OP_SLTUI, OP_ADDI_W, OP_ANDI, OP_ORI, OP_XORI,
        OP_LD_B, OP_LD_H, OP_LD_W, OP_ST_B, OP_ST_H, OP_ST_W, OP_LD_BU, OP_LD_HU,
        OP_LU12I_W, OP_PCADDU12I, OP_JIRL, OP_B, OP_BL,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU
    } enc_op_e;

    typedef enum logic [2:0] {
        FMT_3R, FMT_2RI5, FMT_2RI12S, FMT_2RI12U, FMT_1RI20, FMT_2RI16, FMT_I26, FMT_NONE
    } enc_fmt_e;

    typedef enum logic {S_EMPTY, S_FULL} out_state_e;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_RANGE = 2'd1;
    localparam logic [1:0] ERR_ALIGN = 2'd2;
    localparam logic [1:0] ERR_UNDEF = 2'd3;

    typedef struct packed {
        logic [31:0] base;
        enc_fmt_e    fmt;
    } op_info_t;

    // Base opcode word and field format for an op; unknown codes map to FMT_NONE.
    function automatic op_info_t op_info(input logic [5:0] op);
        op_info_t r;
        r = '{base: 32'h0, fmt: FMT_NONE};
        case (enc_op_e'(op))
            OP_ADD_W:     r = '{32'h00100000, FMT_3R};
            OP_SUB_W:     r = '{32'h00110000, FMT_3R};
            OP_SLT:       r = '{32'h00120000, FMT_3R};
            OP_SLTU:      r = '{32'h00128000, FMT_3R};
            OP_NOR:       r = '{32'h00140000, FMT_3R};
            OP_AND:       r = '{32'h00148000, FMT_3R};
            OP_OR:        r = '{32'h00150000, FMT_3R};
            OP_XOR:       r = '{32'h00158000, FMT_3R};
            OP_SLL_W:     r = '{32'h00170000, FMT_3R};
            OP_SRL_W:     r = '{32'h00178000, FMT_3R};
            OP_SRA_W:     r = '{32'h00180000, FMT_3R};
            OP_SLLI_W:    r = '{32'h00408000, FMT_2RI5};
            OP_SRLI_W:    r = '{32'h00448000, FMT_2RI5};
            OP_SRAI_W:    r = '{32'h00488000, FMT_2RI5};
            OP_SLTI:      r = '{32'h02000000, FMT_2RI12S};
            OP_SLTUI:     r = '{32'h02400000, FMT_2RI12S};
            OP_ADDI_W:    r = '{32'h02800000, FMT_2RI12S};
            OP_ANDI:      r = '{32'h03400000, FMT_2RI12U};
            OP_ORI:       r = '{32'h03800000, FMT_2RI12U};
            OP_XORI:      r = '{32'h03C00000, FMT_2RI12U};
            OP_LD_B:      r = '{32'h28000000, FMT_2RI12S};
            OP_LD_H:      r = '{32'h28400000, FMT_2RI12S};
            OP_LD_W:      r = '{32'h28800000, FMT_2RI12S};
            OP_ST_B:      r = '{32'h29000000, FMT_2RI12S};
            OP_ST_H:      r = '{32'h29400000, FMT_2RI12S};
            OP_ST_W:      r = '{32'h29800000, FMT_2RI12S};
            OP_LD_BU:     r = '{32'h2A000000, FMT_2RI12S};
            OP_LD_HU:     r = '{32'h2A400000, FMT_2RI12S};
            OP_LU12I_W:   r = '{32'h14000000, FMT_1RI20};
            OP_PCADDU12I: r = '{32'h1C000000, FMT_1RI20};
            OP_JIRL:      r = '{32'h4C000000, FMT_2RI16};
            OP_B:         r = '{32'h50000000, FMT_I26};
            OP_BL:        r = '{32'h54000000, FMT_I26};
            OP_BEQ:       r = '{32'h58000000, FMT_2RI16};
            OP_BNE:       r = '{32'h5C000000, FMT_2RI16};
            OP_BLT:       r = '{32'h60000000, FMT_2RI16};
            OP_BGE:       r = '{32'h64000000, FMT_2RI16};
            OP_BLTU:      r = '{32'h68000000, FMT_2RI16};
            OP_BGEU:      r = '{32'h6C000000, FMT_2RI16};
            default:      r = '{32'h0, FMT_NONE};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/la32r_inst_encoder_pack.sv
// Combinational packer: range-checks the immediate and builds the instruction word.
module enc_pack
    import enc_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rj,
    input  logic [4:0]  rk,
    input  logic [31:0] imm,
    output logic [31:0] inst,
    output logic        legal,
    output logic [1:0]  code
);

    op_info_t info;

    // Select field layout by format; alignment is tested before range.
    always_comb begin
        info = op_info(op);
        inst = info.base;
        code = ERR_NONE;
        case (info.fmt)
            FMT_3R: inst = info.base | {17'b0, rk, rj, rd};
            FMT_2RI5: begin
                inst = info.base | {17'b0, imm[4:0], rj, rd};
                if (|imm[31:5]) code = ERR_RANGE;
            end
            FMT_2RI12S: begin
                inst = info.base | {10'b0, imm[11:0], rj, rd};
                if (!(&imm[31:11] || ~|imm[31:11])) code = ERR_RANGE;
            end
            FMT_2RI12U: begin
                inst = info.base | {10'b0, imm[11:0], rj, rd};
                if (|imm[31:12]) code = ERR_RANGE;
            end
            FMT_1RI20: begin
                inst = info.base | {7'b0, imm[19:0], rd};
                if (!(&imm[31:19] || ~|imm[31:19])) code = ERR_RANGE;
            end
            FMT_2RI16: begin
                inst = info.base | {6'b0, imm[17:2], rj, rd};
                if (|imm[1:0])                              code = ERR_ALIGN;
                else if (!(&imm[31:17] || ~|imm[31:17]))    code = ERR_RANGE;
            end
            FMT_I26: begin
                inst = info.base | {6'b0, imm[17:2], imm[27:18]};
                if (|imm[1:0])                              code = ERR_ALIGN;
                else if (!(&imm[31:27] || ~|imm[31:27]))    code = ERR_RANGE;
            end
            default: code = ERR_UNDEF;
        endcase
        legal = (code == ERR_NONE);
    end

endmodule

// File: rtl/la32r_inst_encoder.sv
// Streaming LA32R encoder: request handshake, one-entry output register,
// address counter and emitted-word statistics.
module la32r_inst_encoder
    import enc_pkg::*;
#(
    parameter int          ADDR_W    = 16,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rj,
    input  logic [4:0]        req_rk,
    input  logic [31:0]       req_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_valid,
    output logic [1:0]        err_code,
    output logic [15:0]       inst_cnt
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    out_state_e        state_q, state_d;
    logic [31:0]       inst_q, inst_d;
    logic [ADDR_W-1:0] oaddr_q, oaddr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_valid_q, err_valid_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [15:0]       cnt_q, cnt_d;

    logic [31:0] pk_inst;
    logic        pk_legal;
    logic [1:0]  pk_code;
    logic        hs, accept;

    enc_pack u_pack (
        .op   (req_op),
        .rd   (req_rd),
        .rj   (req_rj),
        .rk   (req_rk),
        .imm  (req_imm),
        .inst (pk_inst),
        .legal(pk_legal),
        .code (pk_code)
    );

    assign out_valid = (state_q == S_FULL);
    assign hs        = out_valid && out_ready;
    // clear blocks acceptance so a request never lands in a word that is being dropped
    assign req_ready = (!out_valid || out_ready) && !clear;
    assign accept    = req_valid && req_ready;

    assign out_inst  = inst_q;
    assign out_addr  = oaddr_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign inst_cnt  = cnt_q;

    // Next-state: output register occupancy, counter advance, error pulse, stats.
    always_comb begin
        state_d     = state_q;
        inst_d      = inst_q;
        oaddr_d     = oaddr_q;
        addr_d      = addr_q;
        err_valid_d = 1'b0;
        err_code_d  = ERR_NONE;
        cnt_d       = cnt_q;
        if (hs && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        if (clear) begin
            state_d = S_EMPTY;
            addr_d  = BASE;
        end else begin
            if (hs) state_d = S_EMPTY;
            if (accept) begin
                if (pk_legal) begin
                    state_d = S_FULL;
                    inst_d  = pk_inst;
                    oaddr_d = addr_q;
                    addr_d  = addr_q + ADDR_W'(4);
                end else begin
                    err_valid_d = 1'b1;
                    err_code_d  = pk_code;
                end
            end
        end
    end

    // State registers; reset drops any pending word at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_EMPTY;
            inst_q      <= '0;
            oaddr_q     <= BASE;
            addr_q      <= BASE;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            inst_q      <= inst_d;
            oaddr_q     <= oaddr_d;
            addr_q      <= addr_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_la32r_inst_encoder.sv
// Scoreboard bench for la32r_inst_encoder: a driver pushes expected words/errors
// from an arithmetic reference model; a negedge monitor pops and compares.
module tb_la32r_inst_encoder;
    import enc_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, clear, req_valid, req_ready;
    logic [5:0]  req_op;
    logic [4:0]  req_rd, req_rj, req_rk;
    logic [31:0] req_imm;
    logic        out_valid, out_ready;
    logic [31:0] out_inst;
    logic [15:0] out_addr;
    logic        err_valid;
    logic [1:0]  err_code;
    logic [15:0] inst_cnt;

    logic rand_mode = 1'b0, rnd_ready = 1'b1, man_ready = 1'b1;
    assign out_ready = rand_mode ? rnd_ready : man_ready;

    // second instance for the small wrapping address space
    logic        s_req_valid, s_req_ready, s_out_valid, s_err_valid;
    logic [31:0] s_out_inst;
    logic [3:0]  s_out_addr;
    logic [1:0]  s_err_code;
    logic [15:0] s_inst_cnt;

    la32r_inst_encoder dut (
        .clk(clk), .resetn(resetn), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rd(req_rd), .req_rj(req_rj), .req_rk(req_rk), .req_imm(req_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
        .err_valid(err_valid), .err_code(err_code), .inst_cnt(inst_cnt)
    );

    la32r_inst_encoder #(.ADDR_W(4), .BASE_ADDR(12)) dut_s (
        .clk(clk), .resetn(resetn), .clear(1'b0),
        .req_valid(s_req_valid), .req_ready(s_req_ready), .req_op(6'd0),
        .req_rd(5'd1), .req_rj(5'd2), .req_rk(5'd3), .req_imm(32'd0),
        .out_valid(s_out_valid), .out_ready(1'b1), .out_inst(s_out_inst), .out_addr(s_out_addr),
        .err_valid(s_err_valid), .err_code(s_err_code), .inst_cnt(s_inst_cnt)
    );

    int checks = 0, errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] inst; logic [15:0] addr; int cyc; } wexp_t;
    typedef struct { logic [1:0] code; int cyc; } eexp_t;
    wexp_t exp_q[$];
    eexp_t err_q[$];
    logic [15:0] addr_m = 16'd0;

    int unsigned bases [0:38] = '{
        32'h00100000, 32'h00110000, 32'h00120000, 32'h00128000, 32'h00140000, 32'h00148000,
        32'h00150000, 32'h00158000, 32'h00170000, 32'h00178000, 32'h00180000,
        32'h00408000, 32'h00448000, 32'h00488000,
        32'h02000000, 32'h02400000, 32'h02800000, 32'h03400000, 32'h03800000, 32'h03C00000,
        32'h28000000, 32'h28400000, 32'h28800000, 32'h29000000, 32'h29400000, 32'h29800000,
        32'h2A000000, 32'h2A400000, 32'h14000000, 32'h1C000000, 32'h4C000000,
        32'h50000000, 32'h54000000, 32'h58000000, 32'h5C000000, 32'h60000000,
        32'h64000000, 32'h68000000, 32'h6C000000 };

    int bnd [0:23] = '{0, 31, 32, -1, -2048, 2047, 2048, -2049, 4095, 4096, 524287, 524288,
                       -524288, -524289, 131068, 131072, -131072, -131076, 134217724,
                       134217728, -134217728, -134217732, 6, -2};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference: op index ranges give the format; values checked as plain integers.
    function automatic void ref_enc(input int op, input int rd, input int rj, input int rk,
                                    input int imm, output logic [31:0] inst, output int code);
        logic [31:0] b;
        code = 0;
        inst = 32'h0;
        if (op > 38) begin
            code = 3;
            return;
        end
        b = bases[op];
        if (op <= 10) begin
            inst = b + rk * 1024 + rj * 32 + rd;
        end else if (op <= 13) begin
            if (imm < 0 || imm > 31) code = 1;
            inst = b + (imm & 31) * 1024 + rj * 32 + rd;
        end else if ((op >= 14 && op <= 16) || (op >= 20 && op <= 27)) begin
            if (imm < -2048 || imm > 2047) code = 1;
            inst = b + (imm & 'hFFF) * 1024 + rj * 32 + rd;
        end else if (op <= 19) begin
            if (imm < 0 || imm > 4095) code = 1;
            inst = b + (imm & 'hFFF) * 1024 + rj * 32 + rd;
        end else if (op <= 29) begin
            if (imm < -524288 || imm > 524287) code = 1;
            inst = b + (imm & 'hFFFFF) * 32 + rd;
        end else if (op == 31 || op == 32) begin
            if (imm % 4 != 0) code = 2;
            else if (imm < -134217728 || imm > 134217724) code = 1;
            inst = b + ((imm >>> 2) & 'hFFFF) * 1024 + ((imm >>> 18) & 'h3FF);
        end else begin
            if (imm % 4 != 0) code = 2;
            else if (imm < -131072 || imm > 131068) code = 1;
            inst = b + ((imm >>> 2) & 'hFFFF) * 1024 + rj * 32 + rd;
        end
    endfunction

    // Present a request until accepted; record the expected outcome at the accept.
    task automatic send(input int op, input int rd, input int rj, input int rk, input int imm);
        logic [31:0] ri;
        int rc;
        bit done;
        done = 1'b0;
        req_op = 6'(op); req_rd = 5'(rd); req_rj = 5'(rj); req_rk = 5'(rk);
        req_imm = imm;
        req_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ref_enc(op, rd, rj, rk, imm, ri, rc);
                if (rc == 0) begin
                    exp_q.push_back('{ri, addr_m, cyc + 1});
                    addr_m = addr_m + 16'd4;
                end else begin
                    err_q.push_back('{2'(rc), cyc + 1});
                end
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!done) fail("send_timeout");
    endtask

    function automatic int rand_imm();
        int v;
        case ($urandom_range(0, 3))
            0: v = int'($urandom_range(0, 80)) - 40;
            1: v = int'($urandom);
            2: v = bnd[$urandom_range(0, 23)];
            default: begin
                v = int'($urandom_range(0, 32'h3FFFF)) - 131072;
                if ($urandom_range(0, 1) == 1) v = v & ~3;
            end
        endcase
        return v;
    endfunction

    initial forever begin
        @(posedge clk);
        #1 rnd_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: words popped on output handshake, errors on err_valid, plus hold stability.
    int          hs_count = 0;
    bit          prev_hold = 1'b0, prev_clear = 1'b0;
    logic [31:0] prev_inst;
    logic [15:0] prev_addr;
    int          first_cyc = 0;
    initial forever begin
        wexp_t w;
        eexp_t e;
        @(negedge clk);
        if (!resetn) begin
            hs_count = 0;
            prev_hold = 1'b0;
            prev_clear = 1'b0;
        end else begin
            chk("inst_cnt", 32'(inst_cnt), 32'(hs_count));
            if (out_valid) begin
                if (prev_hold && !prev_clear) begin
                    chk("hold_inst", out_inst, prev_inst);
                    chk("hold_addr", 32'(out_addr), 32'(prev_addr));
                end
                if (!prev_hold) first_cyc = cyc;
                if (out_ready) begin
                    if (exp_q.size() == 0) fail("unexpected_word");
                    else begin
                        w = exp_q.pop_front();
                        chk("word_inst", out_inst, w.inst);
                        chk("word_addr", 32'(out_addr), 32'(w.addr));
                        chk("word_latency", 32'(first_cyc), 32'(w.cyc));
                    end
                    hs_count++;
                end
            end else if (prev_hold && !prev_clear) begin
                fail("held_word_lost");
            end
            if (err_valid) begin
                if (err_q.size() == 0) fail("unexpected_err");
                else begin
                    e = err_q.pop_front();
                    chk("err_code", 32'(err_code), 32'(e.code));
                    chk("err_latency", 32'(cyc), 32'(e.cyc));
                end
            end
            prev_hold  = out_valid && !out_ready;
            prev_clear = clear;
            prev_inst  = out_inst;
            prev_addr  = out_addr;
        end
    end

    initial begin
        resetn = 1'b0; clear = 1'b0; req_valid = 1'b0; s_req_valid = 1'b0;
        req_op = '0; req_rd = '0; req_rj = '0; req_rk = '0; req_imm = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_inst", out_inst, 0);
        chk("rst_out_addr", 32'(out_addr), 0);
        chk("rst_err_valid", 32'(err_valid), 0);
        chk("rst_err_code", 32'(err_code), 0);
        chk("rst_inst_cnt", 32'(inst_cnt), 0);
        chk("rst_small_addr", 32'(s_out_addr), 12);
        @(posedge clk); #1 resetn = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 1);

        // small instance: address wraps from 12 to 0
        @(posedge clk); #1 s_req_valid = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("wrap_first_addr", 32'(s_out_addr), 12);
        chk("wrap_first_valid", 32'(s_out_valid), 1);
        @(posedge clk); #1 s_req_valid = 1'b0;
        @(negedge clk);
        chk("wrap_second_addr", 32'(s_out_addr), 0);
        @(posedge clk); #1;

        // directed encodings
        send(OP_ADD_W, 1, 2, 3, 0);
        @(negedge clk);
        chk("add_w_inst", out_inst, 32'h00100C41);
        chk("add_w_addr", 32'(out_addr), 0);
        @(posedge clk); #1;
        send(OP_ADDI_W, 4, 0, 0, -1);
        @(negedge clk); chk("addi_w_inst", out_inst, 32'h02BFFC04);
        @(posedge clk); #1;
        send(OP_BEQ, 2, 1, 0, -4);
        @(negedge clk); chk("beq_inst", out_inst, 32'h5BFFFC22);
        @(posedge clk); #1;
        send(OP_BL, 0, 0, 0, 8);
        @(negedge clk); chk("bl_inst", out_inst, 32'h54000800);
        @(posedge clk); #1;

        // rejections
        send(OP_ORI, 1, 1, 0, 4096);
        @(negedge clk);
        chk("ori_range_err", 32'(err_valid), 1);
        chk("ori_range_code", 32'(err_code), 1);
        chk("ori_no_word", 32'(out_valid), 0);
        @(negedge clk);
        chk("err_pulse_one_cycle", 32'(err_valid), 0);
        @(posedge clk); #1;
        send(OP_ADD_W, 5, 6, 7, 0);
        @(negedge clk); chk("counter_unchanged_after_err", 32'(out_addr), 16);
        @(posedge clk); #1;
        send(OP_BEQ, 1, 1, 0, 6);
        @(negedge clk); chk("beq_align_code", 32'(err_code), 2);
        @(posedge clk); #1;
        send(45, 0, 0, 0, 0);
        @(negedge clk); chk("undef_code", 32'(err_code), 3);
        @(posedge clk); #1;

        // clear while FULL with a request waiting
        man_ready = 1'b0;
        send(OP_SUB_W, 1, 1, 1, 0);
        clear = 1'b1;
        req_op = 6'(OP_ADD_W); req_valid = 1'b1;
        @(negedge clk);
        chk("clear_blocks_ready", 32'(req_ready), 0);
        @(posedge clk); #1;
        clear = 1'b0; req_valid = 1'b0;
        void'(exp_q.pop_back());
        addr_m = 16'd0;
        @(negedge clk);
        chk("clear_drops_word", 32'(out_valid), 0);
        @(posedge clk); #1;

        // backpressure: four back-to-back words, consumer stalls three cycles
        fork
            begin
                send(OP_ADD_W, 1, 0, 0, 0);
                send(OP_OR, 2, 0, 0, 0);
                send(OP_SLLI_W, 3, 1, 0, 31);
                send(OP_LU12I_W, 4, 0, 0, -524288);
            end
        join_none
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        chk("bp_first_addr", 32'(out_addr), 0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_req_ready_low", 32'(req_ready), 0);
            @(negedge clk);
        end
        @(posedge clk); #1 man_ready = 1'b1;
        wait fork;
        repeat (2) @(posedge clk); #1;

        // asynchronous reset mid-stream
        man_ready = 1'b0;
        send(OP_XOR, 7, 8, 9, 0);
        #2 resetn = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_out_inst", out_inst, 0);
        chk("arst_out_addr", 32'(out_addr), 0);
        chk("arst_inst_cnt", 32'(inst_cnt), 0);
        chk("arst_err_valid", 32'(err_valid), 0);
        exp_q.delete(); err_q.delete(); addr_m = 16'd0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 resetn = 1'b1; man_ready = 1'b1;

        // randomized stream with random backpressure
        rand_mode = 1'b1;
        for (int n = 0; n < 300; n++) begin
            int op;
            op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(39, 63)) : int'($urandom_range(0, 38));
            send(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), rand_imm());
        end
        rand_mode = 1'b0; man_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("words_drained", 32'(exp_q.size()), 0);
        chk("errs_drained", 32'(err_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
